// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM encoding, default word width and link opcodes for the SPI host.
package spi_pkg;
    localparam int WORD_W_DEF = 16;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEAD  = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_TRAIL = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;
    typedef enum logic [WORD_W_DEF-1:0] {
        NOP         = 16'h0000,
        INIT        = 16'h0001,
        WR_INVERTED = 16'h0002,
        RD_INVERTED = 16'h0003,
        WR_LEDS     = 16'h0004,
        RD_LEDS     = 16'h0005,
        WR_VEC      = 16'h0006,
        RD_VEC      = 16'h0007
    } spi_opcode_e;
endpackage

// File: rtl/spi_master_sckgen.sv
// spi_master_sckgen: SCK half-period generator for one shift window of 2*WORD_W halves.
module spi_master_sckgen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int WORD_W  = WORD_W_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic start,
    output logic sck,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic last_edge
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int HW = $clog2(2 * WORD_W + 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [HW-1:0] HALF_END  = HW'(2 * WORD_W);
    localparam logic [HW-1:0] HALF_LAST_HI = HW'(2 * WORD_W - 1);
    logic [CW-1:0] cnt;
    logic [HW-1:0] half;
    logic tick;
    assign tick = en && cnt == DIV_LAST;
    // Sampling strobe sits one clk after the rise so a same-edge MOSI update has settled.
    assign rise_pulse = en && sck && cnt == '0;
    assign fall_pulse = tick && sck && half != HALF_LAST_HI;
    assign last_edge  = tick && half == HALF_END;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sck  <= 1'b0;
            cnt  <= '0;
            half <= '0;
        end else if (start) begin
            sck  <= 1'b1;
            cnt  <= '0;
            half <= HW'(1);
        end else if (!en) begin
            sck  <= 1'b0;
            cnt  <= '0;
            half <= '0;
        end else if (tick) begin
            sck  <= !sck && half != HALF_END;
            cnt  <= '0;
            half <= half + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/spi_master_host.sv
// spi_master_host: SPI mode-0 master, one WORD_W frame per queued word, back-to-back when possible.
module spi_master_host
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int WORD_W  = WORD_W_DEF,
    parameter int SS_GAP  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_buffer_free,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_data_available,
    input  logic              rd_ack,
    output logic              rd_overrun,
    output logic              busy,
    output logic              SPI_SCK,
    output logic              SPI_SS,
    output logic              SPI_MOSI,
    input  logic              SPI_MISO
);
    localparam int CW = $clog2((CLK_DIV > SS_GAP ? CLK_DIV : SS_GAP) + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(SS_GAP - 1);
    logic [2:0] state;
    logic [CW-1:0] cnt;
    logic [WORD_W-1:0] hold, tx_sr, rx_sr;
    logic hold_full, cnt_done, load, start, sck_rise, sck_fall, last_edge;
    assign cnt_done = cnt == DIV_LAST;
    assign load = hold_full && (state == ST_IDLE || (state == ST_TRAIL && cnt_done));
    assign start = cnt_done && (state == ST_LEAD || (state == ST_TRAIL && hold_full));
    assign wr_buffer_free = !hold_full;
    assign busy = state != ST_IDLE;
    spi_master_sckgen #(.CLK_DIV(CLK_DIV), .WORD_W(WORD_W)) u_sckgen (
        .clk(clk),
        .reset_n(reset_n),
        .en(state == ST_SHIFT),
        .start(start),
        .sck(SPI_SCK),
        .rise_pulse(sck_rise),
        .fall_pulse(sck_fall),
        .last_edge(last_edge)
    );
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            SPI_SS            <= 1'b1;
            SPI_MOSI          <= 1'b0;
            hold              <= '0;
            hold_full         <= 1'b0;
            tx_sr             <= '0;
            rx_sr             <= '0;
            rd_data           <= '0;
            rd_data_available <= 1'b0;
            rd_overrun        <= 1'b0;
        end else begin
            if (load) hold_full <= 1'b0;
            else if (wr_en && !hold_full) begin
                hold_full <= 1'b1;
                hold      <= wr_data;
            end
            if (load) begin
                SPI_MOSI <= hold[WORD_W-1];
                tx_sr    <= {hold[WORD_W-2:0], 1'b0};
            end else if (sck_fall) begin
                SPI_MOSI <= tx_sr[WORD_W-1];
                tx_sr    <= {tx_sr[WORD_W-2:0], 1'b0};
            end
            if (sck_rise) rx_sr <= {rx_sr[WORD_W-2:0], SPI_MISO};
            rd_overrun <= last_edge && rd_data_available && !rd_ack;
            if (last_edge) begin
                rd_data           <= rx_sr;
                rd_data_available <= 1'b1;
            end else if (rd_ack) rd_data_available <= 1'b0;
            case (state)
                ST_IDLE: if (hold_full) begin
                    state  <= ST_LEAD;
                    cnt    <= '0;
                    SPI_SS <= 1'b0;
                end
                ST_LEAD: if (cnt_done) state <= ST_SHIFT; else cnt <= cnt + 1'b1;
                ST_SHIFT: if (last_edge) begin
                    state <= ST_TRAIL;
                    cnt   <= '0;
                end
                ST_TRAIL: if (!cnt_done) cnt <= cnt + 1'b1;
                else if (hold_full) state <= ST_SHIFT;
                else begin
                    state  <= ST_GAP;
                    cnt    <= '0;
                    SPI_SS <= 1'b1;
                end
                ST_GAP: if (cnt == GAP_LAST) state <= ST_IDLE; else cnt <= cnt + 1'b1;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_host.sv
// tb_spi_master_host: directed checks of a loopback CLK_DIV=2 host and an inverting-slave CLK_DIV=3 host.
module tb_spi_master_host;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int total = 0, bad = 0;
    logic rn, we, ack, free, avail, ovr, busy, sck, ss, mosi;
    logic [15:0] wd, rd;
    logic rn3, we3, ack3, free3, avail3, ovr3, busy3, sck3, ss3, mosi3, miso3;
    logic [15:0] wd3, rd3;
    assign miso3 = ~mosi3;
    spi_master_host #(.CLK_DIV(2), .WORD_W(16), .SS_GAP(2)) dut (
        .clk(clk), .reset_n(rn), .wr_en(we), .wr_data(wd), .wr_buffer_free(free),
        .rd_data(rd), .rd_data_available(avail), .rd_ack(ack), .rd_overrun(ovr), .busy(busy),
        .SPI_SCK(sck), .SPI_SS(ss), .SPI_MOSI(mosi), .SPI_MISO(mosi)
    );
    spi_master_host #(.CLK_DIV(3), .WORD_W(16), .SS_GAP(2)) dut3 (
        .clk(clk), .reset_n(rn3), .wr_en(we3), .wr_data(wd3), .wr_buffer_free(free3),
        .rd_data(rd3), .rd_data_available(avail3), .rd_ack(ack3), .rd_overrun(ovr3), .busy(busy3),
        .SPI_SCK(sck3), .SPI_SS(ss3), .SPI_MOSI(mosi3), .SPI_MISO(miso3)
    );
    int rises = 0, rises3 = 0, hi3 = 0, ss_falls = 0;
    logic [31:0] cap = '0;
    logic sck_q = 1'b0, sck3_q = 1'b0, ss_q = 1'b1;
    // Edge monitors run 1 time unit after each clk edge; the stimulus thread samples at 3.
    always @(posedge clk) begin
        #1;
        if (sck && !sck_q) begin
            rises++;
            cap = {cap[30:0], mosi};
        end
        if (!ss && ss_q) ss_falls++;
        if (sck3 && !sck3_q) rises3++;
        if (sck3) hi3++;
        sck_q = sck;
        sck3_q = sck3;
        ss_q = ss;
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic test_reset;
        rn = 0; we = 0; ack = 0; wd = '0;
        rn3 = 0; we3 = 0; ack3 = 0; wd3 = '0;
        cyc(5);
        rn = 1; rn3 = 1;
        cyc();
        total++; if (ss !== 1'b1) begin bad++; $display("FAIL reset_ss got=%b want=1", ss); end
        total++; if (sck !== 1'b0) begin bad++; $display("FAIL reset_sck got=%b want=0", sck); end
        total++; if (mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi got=%b want=0", mosi); end
        total++; if (free !== 1'b1) begin bad++; $display("FAIL reset_free got=%b want=1", free); end
        total++; if (avail !== 1'b0) begin bad++; $display("FAIL reset_avail got=%b want=0", avail); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (rd !== 16'h0) begin bad++; $display("FAIL reset_rd got=%h want=0000", rd); end
    endtask

    task automatic test_single;
        int n, ss_at, r0;
        r0 = rises; ss_at = -1;
        we = 1; wd = 16'hA55A;
        cyc(); we = 0; n = 1;
        total++; if (free !== 1'b0) begin bad++; $display("FAIL single_free got=%b want=0", free); end
        while (!avail && n < 200) begin
            if (ss_at < 0 && !ss) ss_at = n;
            cyc(); n++;
        end
        total++; if (n != 68) begin bad++; $display("FAIL single_latency got=%0d want=68", n); end
        total++; if (ss_at != 2) begin bad++; $display("FAIL single_ss_low got=%0d want=2", ss_at); end
        total++; if (rd !== 16'hA55A) begin bad++; $display("FAIL single_rd got=%h want=a55a", rd); end
        total++; if (cap[15:0] !== 16'hA55A) begin bad++; $display("FAIL single_mosi got=%h want=a55a", cap[15:0]); end
        total++; if (rises - r0 != 16) begin bad++; $display("FAIL single_sck_pulses got=%0d want=16", rises - r0); end
        total++; if (ss !== 1'b0) begin bad++; $display("FAIL single_ss_trail got=%b want=0", ss); end
        cyc(2);
        total++; if (ss !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL single_gap got ss=%b busy=%b want ss=1 busy=1", ss, busy); end
        cyc(2);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b want=0", busy); end
        ack = 1; cyc(); ack = 0;
        total++; if (avail !== 1'b0) begin bad++; $display("FAIL single_ack got=%b want=0", avail); end
    endtask

    task automatic test_back_to_back;
        int n, r0, f0;
        r0 = rises; f0 = ss_falls;
        we = 1; wd = 16'h0102; cyc(); we = 0;
        cyc(8);
        total++; if (free !== 1'b1) begin bad++; $display("FAIL b2b_free got=%b want=1", free); end
        we = 1; wd = 16'h8001; cyc(); we = 0;
        n = 0; while (!avail && n < 300) begin cyc(); n++; end
        total++; if (rd !== 16'h0102 || avail !== 1'b1) begin bad++; $display("FAIL b2b_first got=%h avail=%b want=0102 avail=1", rd, avail); end
        ack = 1; cyc(); ack = 0;
        n = 0; while (!avail && n < 300) begin cyc(); n++; end
        total++; if (rd !== 16'h8001 || avail !== 1'b1) begin bad++; $display("FAIL b2b_second got=%h avail=%b want=8001 avail=1", rd, avail); end
        ack = 1; cyc(); ack = 0;
        n = 0; while (busy && n < 300) begin cyc(); n++; end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b want=0", busy); end
        total++; if (rises - r0 != 32) begin bad++; $display("FAIL b2b_sck_pulses got=%0d want=32", rises - r0); end
        total++; if (ss_falls - f0 != 1) begin bad++; $display("FAIL b2b_ss_windows got=%0d want=1", ss_falls - f0); end
        total++; if (cap !== 32'h01028001) begin bad++; $display("FAIL b2b_mosi got=%h want=01028001", cap); end
    endtask

    task automatic test_overrun;
        int n, pulses, p2;
        logic [15:0] rd_at;
        pulses = 0; p2 = 0; rd_at = '0;
        we = 1; wd = 16'h1111; cyc(); we = 0;
        n = 0; while (!free && n < 50) begin cyc(); n++; end
        we = 1; wd = 16'h2222; cyc(); we = 0;
        n = 0;
        while (busy && n < 400) begin
            if (ovr) begin pulses++; rd_at = rd; end
            cyc(); n++;
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL ovr_pulses got=%0d want=1", pulses); end
        total++; if (rd_at !== 16'h2222) begin bad++; $display("FAIL ovr_rd_at_pulse got=%h want=2222", rd_at); end
        total++; if (rd !== 16'h2222 || avail !== 1'b1) begin bad++; $display("FAIL ovr_rd got=%h avail=%b want=2222 avail=1", rd, avail); end
        we = 1; wd = 16'h3333; cyc(); we = 0;
        for (int i = 1; i < 68; i++) begin
            ack = (i == 67);
            if (ovr) p2++;
            cyc();
        end
        ack = 0;
        total++; if (ovr !== 1'b0 || p2 != 0) begin bad++; $display("FAIL ack_no_ovr got=%b early=%0d want=0 early=0", ovr, p2); end
        total++; if (rd !== 16'h3333 || avail !== 1'b1) begin bad++; $display("FAIL ack_rd got=%h avail=%b want=3333 avail=1", rd, avail); end
        ack = 1; cyc(); ack = 0;
        n = 0; while (busy && n < 50) begin cyc(); n++; end
    endtask

    task automatic test_full_buffer;
        int n, r0, f0;
        r0 = rises; f0 = ss_falls;
        we = 1; wd = 16'h00F0; cyc();
        total++; if (free !== 1'b0) begin bad++; $display("FAIL full_free_low got=%b want=0", free); end
        wd = 16'hFFFF; cyc(); we = 0;
        total++; if (free !== 1'b1) begin bad++; $display("FAIL full_free_back got=%b want=1", free); end
        n = 0; while (busy && n < 300) begin cyc(); n++; end
        total++; if (rd !== 16'h00F0) begin bad++; $display("FAIL full_rd got=%h want=00f0", rd); end
        total++; if (cap[15:0] !== 16'h00F0) begin bad++; $display("FAIL full_mosi got=%h want=00f0", cap[15:0]); end
        total++; if (rises - r0 != 16 || ss_falls - f0 != 1) begin bad++; $display("FAIL full_one_frame got pulses=%0d windows=%0d want 16 1", rises - r0, ss_falls - f0); end
        ack = 1; cyc(); ack = 0;
    endtask

    task automatic test_midframe_reset;
        int n, r0, h0;
        r0 = rises3;
        we3 = 1; wd3 = 16'h5555; cyc(); we3 = 0;
        n = 0; while (ss3 && n < 20) begin cyc(); n++; end
        we3 = 1; wd3 = 16'h7777; cyc(); we3 = 0;
        total++; if (free3 !== 1'b0) begin bad++; $display("FAIL mid_queued got=%b want=0", free3); end
        n = 0; while (rises3 - r0 < 7 && n < 200) begin cyc(); n++; end
        rn3 = 0; cyc();
        total++; if ({ss3, sck3, mosi3, free3} !== 4'b1001) begin bad++; $display("FAIL mid_reset_pins got ss,sck,mosi,free=%b want=1001", {ss3, sck3, mosi3, free3}); end
        total++; if ({avail3, busy3, ovr3} !== 3'b000 || rd3 !== 16'h0) begin bad++; $display("FAIL mid_reset_status got avail,busy,ovr=%b rd=%h want=000 rd=0000", {avail3, busy3, ovr3}, rd3); end
        rn3 = 1; cyc(10);
        total++; if (busy3 !== 1'b0 || ss3 !== 1'b1) begin bad++; $display("FAIL mid_discard got busy=%b ss=%b want busy=0 ss=1", busy3, ss3); end
        r0 = rises3; h0 = hi3;
        we3 = 1; wd3 = 16'h1234; cyc(); we3 = 0; n = 1;
        while (!avail3 && n < 300) begin cyc(); n++; end
        total++; if (n != 101) begin bad++; $display("FAIL div3_latency got=%0d want=101", n); end
        total++; if (rd3 !== 16'hEDCB) begin bad++; $display("FAIL div3_rd got=%h want=edcb", rd3); end
        total++; if (rises3 - r0 != 16) begin bad++; $display("FAIL div3_sck_pulses got=%0d want=16", rises3 - r0); end
        total++; if (hi3 - h0 != 48) begin bad++; $display("FAIL div3_high_cycles got=%0d want=48", hi3 - h0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_full_buffer();
        test_midframe_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
